reset_sequencer: RTL
====================

RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 Parameter HOLD_CYCLES, default 4: hold cycles in ASSERT and IO_HOLD; legal range 1..255.
REQ-002 Parameter ACK_TIMEOUT, default 255: maximum MEM_WAIT cycles before timeout; legal range 1..255.
REQ-003 Port clk  in  1  system clock; all flops on rising edge.
REQ-004 Port reset  in  1  asynchronous, active-low; 0 = sequencer reset.
REQ-005 Port soft_req  in  1  software reset request; honoured only in RUN.
REQ-006 Port mem_init_done  in  1  memory-init acknowledge; level.
REQ-007 Port mem_rst  out  1  memory reset; active-high.
REQ-008 Port io_rst  out  1  I/O reset; active-high.
REQ-009 Port core_rst  out  1  processor core reset; active-high.
REQ-010 Port sys_ready  out  1  1 only in RUN.
REQ-011 Port timeout_err  out  1  sticky acknowledge-timeout flag.
REQ-012 Port state  out  3  current state code.

Function
REQ-013 All outputs SHALL be registered, with no combinational path from any input to any output.
REQ-014 State codes SHALL be: ASSERT=0, MEM_WAIT=1, IO_HOLD=2, CORE_REL=3, RUN=4; codes 5..7 SHALL go to ASSERT on the next edge.
REQ-015 ASSERT: mem_rst=io_rst=core_rst=1, sys_ready=0; 8-bit counter counts HOLD_CYCLES edges, then next state MEM_WAIT, counter cleared.
REQ-016 MEM_WAIT: mem_rst=0, others 1; mem_init_done sampled each edge; sampled 1 -> IO_HOLD, counter cleared.
REQ-017 IO_HOLD: mem_rst=io_rst=0, core_rst=1; after HOLD_CYCLES edges -> CORE_REL.
REQ-018 CORE_REL: all three resets 0, sys_ready=0; exactly one cycle, then RUN.
REQ-019 RUN: all resets 0, sys_ready=1; stays until soft-reset event.
REQ-020 Soft-reset event = soft_req 0->1 edge detected from a registered copy; in RUN -> ASSERT on the next edge, all resets 1 in that same cycle.
REQ-021 soft_req held high SHALL trigger once only; a new 0->1 edge is required.
REQ-022 soft_req edges outside RUN SHALL be discarded and SHALL NOT be queued.
REQ-023 mem_init_done falling outside MEM_WAIT SHALL be ignored.
REQ-024 Minimum latency from reset release to sys_ready=1 SHALL be 2*HOLD_CYCLES+3 edges when mem_init_done is already 1.

Reset
REQ-025 reset low SHALL asynchronously force: state=ASSERT, counter=0, mem_rst=io_rst=core_rst=1, sys_ready=0, timeout_err=0, soft_req edge register=0.
REQ-026 reset assertion mid-sequence, in any state, SHALL restart the full sequence from ASSERT after release.
REQ-027 The first edge after release SHALL count as ASSERT cycle 1.

Configuration
REQ-028 Macro RST_SEQ_WDT_EN defined: MEM_WAIT counts cycles; when the count reaches ACK_TIMEOUT with mem_init_done still 0, timeout_err SHALL be set to 1 (sticky until reset) and state SHALL go to ASSERT, retrying indefinitely.
REQ-029 Macro RST_SEQ_WDT_EN undefined: MEM_WAIT SHALL wait indefinitely and timeout_err SHALL be tied to 0.
REQ-030 If acknowledge and timeout occur on the same edge, the acknowledge SHALL win: go to IO_HOLD, no error.

Verification (HOLD_CYCLES=4, ACK_TIMEOUT=255)
REQ-031 Release reset with mem_init_done=1 -> state 0,0,0,0,1,2,2,2,2,3,4; sys_ready=1 at edge 11.
REQ-032 mem_init_done raised 20 cycles into MEM_WAIT -> IO_HOLD on the following edge; no timeout_err.
REQ-033 soft_req pulse in RUN -> next edge: all resets=1, sys_ready=0, state=0; full sequence repeats; soft_req held high does not retrigger.
REQ-034 soft_req pulsed during IO_HOLD -> ignored; RUN reached on schedule and stays.
REQ-035 With RST_SEQ_WDT_EN, mem_init_done=0 -> after 255 MEM_WAIT cycles timeout_err=1, state=0; later ack reaches RUN with timeout_err still 1.
REQ-036 reset pulled low in IO_HOLD -> outputs reset immediately, without waiting for clk; sequence restarts from ASSERT.

Source files
------------

// File: rtl/reset_sequencer.sv
// Power-on / soft reset sequencer: releases memory, I/O and core resets in order, then flags ready.
// Optional acknowledge watchdog in MEM_WAIT enabled by defining RST_SEQ_WDT_EN.
module reset_sequencer #(
   parameter int HOLD_CYCLES = 4,
   parameter int ACK_TIMEOUT = 255
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       soft_req,
   input  logic       mem_init_done,
   output logic       mem_rst,
   output logic       io_rst,
   output logic       core_rst,
   output logic       sys_ready,
   output logic       timeout_err,
   output logic [2:0] state
);

   typedef enum logic [2:0] {
      ST_ASSERT   = 3'd0,
      ST_MEM_WAIT = 3'd1,
      ST_IO_HOLD  = 3'd2,
      ST_CORE_REL = 3'd3,
      ST_RUN      = 3'd4
   } seqState_e;

   // ASSERT starts counting from a cleared counter on its first edge, while IO_HOLD
   // counts its entry edge, so the two terminal counts differ by one.
   localparam logic [7:0] ASSERT_LAST = 8'(HOLD_CYCLES);
   localparam logic [7:0] IOHOLD_LAST = 8'(HOLD_CYCLES - 1);
   localparam logic [7:0] ACK_LAST    = 8'(ACK_TIMEOUT - 1);

   seqState_e  state_q, state_d;
   logic [7:0] cnt_q, cnt_d;
   logic       softPrev_q;
   logic       softEvent;
   logic       memRst_q, memRst_d;
   logic       ioRst_q, ioRst_d;
   logic       coreRst_q, coreRst_d;
   logic       sysReady_q, sysReady_d;
`ifdef RST_SEQ_WDT_EN
   logic       timeoutErr_q, timeoutErr_d;
`endif

   assign softEvent = soft_req & ~softPrev_q;

   always_comb begin
      state_d = ST_ASSERT;
      cnt_d   = 8'd0;
`ifdef RST_SEQ_WDT_EN
      timeoutErr_d = timeoutErr_q;
`endif
      case (state_q)
         ST_ASSERT: begin
            if (cnt_q == ASSERT_LAST) begin
               state_d = ST_MEM_WAIT;
            end else begin
               state_d = ST_ASSERT;
               cnt_d   = cnt_q + 8'd1;
            end
         end
         ST_MEM_WAIT: begin
            // Acknowledge is tested first so it wins over a simultaneous timeout.
            if (mem_init_done) begin
               state_d = ST_IO_HOLD;
`ifdef RST_SEQ_WDT_EN
            end else if (cnt_q == ACK_LAST) begin
               state_d      = ST_ASSERT;
               timeoutErr_d = 1'b1;
`endif
            end else begin
               state_d = ST_MEM_WAIT;
               cnt_d   = (cnt_q == ACK_LAST) ? cnt_q : cnt_q + 8'd1;
            end
         end
         ST_IO_HOLD: begin
            if (cnt_q == IOHOLD_LAST) begin
               state_d = ST_CORE_REL;
            end else begin
               state_d = ST_IO_HOLD;
               cnt_d   = cnt_q + 8'd1;
            end
         end
         ST_CORE_REL: begin
            state_d = ST_RUN;
         end
         ST_RUN: begin
            state_d = softEvent ? ST_ASSERT : ST_RUN;
         end
         default: begin
            state_d = ST_ASSERT;
         end
      endcase
   end

   // Outputs are decoded from the next state so they change on the same edge as state.
   always_comb begin
      memRst_d   = (state_d == ST_ASSERT);
      ioRst_d    = (state_d == ST_ASSERT) || (state_d == ST_MEM_WAIT);
      coreRst_d  = (state_d == ST_ASSERT) || (state_d == ST_MEM_WAIT) ||
                   (state_d == ST_IO_HOLD);
      sysReady_d = (state_d == ST_RUN);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= ST_ASSERT;
         cnt_q      <= 8'd0;
         softPrev_q <= 1'b0;
         memRst_q   <= 1'b1;
         ioRst_q    <= 1'b1;
         coreRst_q  <= 1'b1;
         sysReady_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         softPrev_q <= soft_req;
         memRst_q   <= memRst_d;
         ioRst_q    <= ioRst_d;
         coreRst_q  <= coreRst_d;
         sysReady_q <= sysReady_d;
      end
   end

`ifdef RST_SEQ_WDT_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         timeoutErr_q <= 1'b0;
      end else begin
         timeoutErr_q <= timeoutErr_d;
      end
   end

   assign timeout_err = timeoutErr_q;
`else
   assign timeout_err = 1'b0;
`endif

   assign mem_rst   = memRst_q;
   assign io_rst    = ioRst_q;
   assign core_rst  = coreRst_q;
   assign sys_ready = sysReady_q;
   assign state     = state_q;

endmodule
